// File: rtl/gpa_spi_pkg.sv
// Shared types and constants for the GPA-FHDO SPI transfer engine.
package gpa_spi_pkg;

    localparam int RD_FLAG_BIT = 30;
    localparam int PAYLOAD_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_TRAIL,
        ST_GAP
    } state_t;

    // Number of SCLK periods in a frame, selected by the command's read flag.
    function automatic int frame_len(input logic rd, input int word_w, input int rd_bits);
        return rd ? rd_bits : word_w;
    endfunction

endpackage

// File: rtl/gpa_word_fifo.sv
// Synchronous word FIFO with async reset; full/empty/level derived from wrap-bit pointers.
module gpa_word_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wptr - rptr;
    assign full    = (level == FULL_LVL);
    assign empty   = (wptr == rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    // NOTE: storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/gpa_spi_xfer_engine.sv
// SPI transfer engine for the GPA-FHDO DAC/ADC link: word FIFO, framed SCLK/CSN/SDO, atomic ADC capture.
module gpa_spi_xfer_engine
    import gpa_spi_pkg::*;
#(
    parameter int WORD_W     = 24,
    parameter int RD_BITS    = 32,
    parameter int RX_W       = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 6,
    parameter int CS_GAP     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [DIV_W-1:0]              spi_clk_div_i,
    output logic [RX_W-1:0]               adc_value_o,
    output logic                          adc_valid_o,
    output logic                          fhd_clk_o,
    output logic                          fhd_sdo_o,
    output logic                          fhd_csn_o,
    input  logic                          fhd_sdi_i,
    output logic                          busy_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int MAX_N = (RD_BITS > WORD_W) ? RD_BITS : WORD_W;
    localparam int CNT_W = $clog2(MAX_N + 1);
    localparam int GAP_W = $clog2(2 * CS_GAP + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CAP_START = CNT_W'(RD_BITS - RX_W);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(2 * CS_GAP - 1);

    state_t            state;
    state_t            state_n;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W:0]   fifo_rdata;

    logic [WORD_W-1:0] shreg;
    logic              rd_lat;
    logic [CNT_W-1:0]  n_lat;
    logic [DIV_W-1:0]  div_lat;
    logic [DIV_W-1:0]  div_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [RX_W-1:0]   cap;

    logic              half_end;
    logic              last_bit;
    logic              gap_end;
    logic              unused_bits;

    assign unused_bits = ^data_i;

    gpa_word_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (valid_i),
        .wdata ({data_i[RD_FLAG_BIT], data_i[PAYLOAD_LSB +: WORD_W]}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level_o)
    );

    assign ready_o  = !fifo_full;
    assign busy_o   = (state != ST_IDLE) || !fifo_empty;
    assign half_end = (div_cnt == div_lat);
    assign last_bit = ((bit_cnt + CNT_ONE) == n_lat);
    assign gap_end  = half_end && (gap_cnt == GAP_LAST);

    assign fhd_csn_o = !(state inside {ST_LEAD, ST_SHIFT_HI, ST_SHIFT_LO, ST_TRAIL});
    assign fhd_clk_o = (state == ST_SHIFT_HI);
    assign fhd_sdo_o = (state == ST_SHIFT_HI) && shreg[WORD_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // The last GAP cycle may pop directly so queued frames see exactly CS_GAP*2H of CSN high.
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
        state_n = state;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = ST_LEAD;
                end
            end
            ST_LEAD:     if (half_end) state_n = ST_SHIFT_HI;
            ST_SHIFT_HI: if (half_end) state_n = ST_SHIFT_LO;
            ST_SHIFT_LO: if (half_end) state_n = last_bit ? ST_TRAIL : ST_SHIFT_HI;
            ST_TRAIL:    if (half_end) state_n = ST_GAP;
            ST_GAP: begin
                if (gap_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_n = ST_LEAD;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg       <= '0;
            rd_lat      <= 1'b0;
            n_lat       <= '0;
            div_lat     <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            cap         <= '0;
            adc_value_o <= '0;
            adc_valid_o <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            adc_valid_o <= 1'b0;
            if (valid_i && fifo_full) overflow_o <= 1'b1;

            if (pop) begin
                shreg   <= fifo_rdata[WORD_W-1:0];
                rd_lat  <= fifo_rdata[WORD_W];
                n_lat   <= CNT_W'(frame_len(fifo_rdata[WORD_W], WORD_W, RD_BITS));
                div_lat <= spi_clk_div_i;
                div_cnt <= '0;
                bit_cnt <= '0;
                gap_cnt <= '0;
            end else if (state != ST_IDLE) begin
                div_cnt <= half_end ? '0 : div_cnt + DIV_ONE;

                // Sample SDI on the edge that drives SCLK low; only the trailing RX_W bits are kept.
                if (state == ST_SHIFT_HI && half_end && rd_lat && bit_cnt >= CAP_START)
                    cap <= RX_W'({cap, fhd_sdi_i});

                if (state == ST_SHIFT_LO && half_end) begin
                    bit_cnt <= bit_cnt + CNT_ONE;
                    shreg   <= shreg << 1;
                end

                if (state == ST_TRAIL && half_end) begin
                    gap_cnt <= '0;
                    if (rd_lat) begin
                        adc_value_o <= cap;
                        adc_valid_o <= 1'b1;
                    end
                end

                if (state == ST_GAP && half_end) gap_cnt <= gap_cnt + GAP_ONE;
            end
        end
    end

endmodule

// File: doc/gpa_spi_xfer_engine.md
Name: gpa_spi_xfer_engine

Overview:
Parametrised SPI transfer engine that drives the GPA-FHDO DAC/ADC link. It sits between the gradient memory core and the board pins. A small word FIFO decouples bursts from the gradient core, so back-to-back words are absorbed rather than lost. The SCLK divider is restarted at every frame start, which removes output jitter. The block adds a read mode with atomic ADC capture, a guaranteed chip-select gap between frames, and an overflow flag.

Parameters:
WORD_W, 24, write-frame length in bits; payload is data_i[WORD_W-1:0] (WORD_W <= 30)
RD_BITS, 32, read-frame length in bits
RX_W, 16, ADC bits captured from the last RX_W bits of a read frame (RX_W <= RD_BITS)
FIFO_DEPTH, 4, input word FIFO depth (power of 2, >= 2)
DIV_W, 6, width of the clock-divider input
CS_GAP, 1, minimum fhd_csn_o high time between frames, in SCLK periods

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
data_i  in  32  command word; [WORD_W-1:0] payload, [30] read-mode flag
valid_i  in  1  push strobe; one word per cycle
ready_o  out  1  FIFO not full
spi_clk_div_i  in  DIV_W  half-period H = spi_clk_div_i+1 clk cycles
adc_value_o  out  RX_W  last captured ADC word
adc_valid_o  out  1  one-cycle pulse when adc_value_o updates
fhd_clk_o  out  1  SCLK (CPOL=0)
fhd_sdo_o  out  1  serial data to board, MSB first
fhd_csn_o  out  1  chip select, active low
fhd_sdi_i  in  1  serial data from board
busy_o  out  1  FSM not IDLE or FIFO non-empty
overflow_o  out  1  sticky: a push was attempted while full
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, any time, including mid-frame): fhd_csn_o=1, fhd_clk_o=0, fhd_sdo_o=0, busy_o=0, adc_value_o=0, adc_valid_o=0, overflow_o=0, ready_o=1. FIFO is flushed and FSM goes to IDLE. The partial frame is abandoned with no ADC update.
- Push: accepted iff valid_i && ready_o. If valid_i && !ready_o, the word is dropped and overflow_o is set. There is no bypass; a pop in the same cycle does not rescue a push into a full FIFO.
- FSM states: IDLE, LEAD, SHIFT_HI, SHIFT_LO, TRAIL, GAP.
- IDLE: when the FIFO is non-empty, pop the word and latch payload, read flag, N (WORD_W or RD_BITS) and H. Bit counter := 0, divider := 0. Go to LEAD.
- LEAD (H cycles): fhd_csn_o=0, fhd_clk_o=0, fhd_sdo_o=0.
- SHIFT_HI (H cycles): fhd_clk_o=1. fhd_sdo_o = payload bit (WORD_W-1-k) at entry while k<WORD_W, else 0.
- SHIFT_LO (H cycles): fhd_clk_o=0. On the edge that drives SCLK low, if read mode and k >= N-RX_W, shift fhd_sdi_i into the capture register. Then k++. If k==N go to TRAIL, else go to SHIFT_HI.
- TRAIL (H cycles): fhd_csn_o=0, fhd_sdo_o=0. On exit: fhd_csn_o=1; in read mode, adc_value_o := capture register and adc_valid_o pulses for 1 cycle.
- GAP (CS_GAP*2H cycles): fhd_csn_o=1, then go to IDLE.
- Frame timing: csn-low time = H + 2H*N + H clk cycles. Exactly N SCLK rising edges per frame.
- Latency: with valid_i at cycle T, FIFO empty and FSM in IDLE, fhd_csn_o falls at T+2 and the first SCLK rise is at T+2+H. This latency is fixed and independent of history.
- spi_clk_div_i and data_i changes mid-frame have no effect on the current frame.
- div=0 gives H=1, i.e. SCLK = clk/2.
- adc_value_o never shows a partial word.
- busy_o deasserts the cycle the FSM returns to IDLE with the FIFO empty.

Decomposition:
- Package gpa_spi_pkg: FSM state enum; field constants RD_FLAG_BIT=30 and PAYLOAD_LSB=0; function for the frame length N.
- Sub-module gpa_word_fifo: synchronous FIFO parametrised by width and depth, with async reset, push/pop, full/empty and level outputs.
- Divider counter, bit counter and shift/capture registers live in the top level.

Test Plan:
- div=1 (H=2), push 0x00ABCDE1 write → csn low for 2+96+2=100 cycles, 24 SCLK rises, SDO stream 0xABCDE1 MSB first, SCLK high/low 2 cycles each, adc_valid_o never pulses.
- div=0, push 0x40000000; SDI model drives 0xBEEF on the last 16 bits → 32 SCLK rises, adc_value_o=0xBEEF, exactly one adc_valid_o pulse at csn rise, SDO=0 after bit 24.
- Idle engine, valid_i held for 6 consecutive cycles, div=3 → word 1 popped immediately, words 2-5 queued, word 6 dropped, overflow_o=1, 5 frames emitted in order, fifo_level_o peaks at 4.
- CS_GAP=1, H=2, two queued words → csn high for exactly 4 cycles between frames; first SCLK rise of each frame is H=2 cycles after its csn fall.
- Change spi_clk_div_i from 1 to 5 at mid-frame → current frame keeps H=2; the next frame uses H=6.
- Assert rst at bit 10 of a read frame → outputs take reset values within the same cycle, no adc_valid_o pulse, FIFO empty, next push starts a clean frame with the T+2 latency.
